i2c_target: RTL



---
 rtl/i2c_pkg.sv | 28 ++
 rtl/i2c_target_if.sv | 39 +++
 rtl/i2c_line_filter.sv | 74 +++++++
 rtl/i2c_target.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and constants for the I2C target endpoint.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int   I2C_ADDR_WIDTH = 7;
    localparam int   I2C_BYTE_WIDTH = 8;
    localparam logic I2C_ACK        = 1'b0;
    localparam logic I2C_NACK       = 1'b1;

    // Protocol state of the target.
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_ADDR       = 4'd1,
        ST_IGNORE     = 4'd2,
        ST_ADDR_ACK   = 4'd3,
        ST_WRITE_BYTE = 4'd4,
        ST_WRITE_ACK  = 4'd5,
        ST_READ_LOAD  = 4'd6,
        ST_READ_BYTE  = 4'd7,
        ST_READ_ACK   = 4'd8
    } i2c_state_e;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_target_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_if
// Description : Byte handshake and status bundle between the I2C target and
//               the on-chip logic that consumes writes / supplies reads.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_target_if;
    import i2c_pkg::*;

    logic                      start_seen;
    logic                      stop_seen;
    logic                      addressed;
    logic                      read_mode;
    logic [I2C_BYTE_WIDTH-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_nack;
    logic                      tx_request;
    logic                      tx_valid;
    logic [I2C_BYTE_WIDTH-1:0] tx_data;
    logic                      master_nack;
    logic                      tx_underrun;

    // Target side: reports bus events, consumes read data.
    modport slave (
        output start_seen, stop_seen, addressed, read_mode,
        output rx_data, rx_valid, tx_request, master_nack, tx_underrun,
        input  rx_nack, tx_valid, tx_data
    );

    // Register-file side: observes events, supplies read data.
    modport master (
        input  start_seen, stop_seen, addressed, read_mode,
        input  rx_data, rx_valid, tx_request, master_nack, tx_underrun,
        output rx_nack, tx_valid, tx_data
    );

endinterface : i2c_target_if
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_filter
// Description : 2-flop synchronizer followed by a glitch filter that only
//               changes the output level after FILTER_DEPTH equal samples.
//               Provides the filtered level and one-cycle rise/fall pulses
//               aligned with the first cycle of the new level.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_filter #(
    parameter int FILTER_DEPTH = 3
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int             CNT_W    = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_DEPTH - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Register stage; an idle open-drain bus reads high.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count consecutive samples that disagree with the level; flip on the last.
    always_comb begin
        sync1_d = line_in;
        sync2_d = sync1_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule : i2c_line_filter
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target
// Description : I2C target endpoint answering one 7-bit address. Write bytes
//               are delivered on rx_data/rx_valid, read bytes are fetched via
//               tx_request/tx_valid, with optional SCL stretching.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_WIDTH-1:0] ADDRESS          = 7'h36,
    parameter bit                        CLOCK_STRETCHING = 1'b1,
    parameter int                        FILTER_DEPTH     = 3,
    parameter int                        SDA_HOLD         = 4
) (
    input  logic          clk_in,
    input  logic          rst_n,
    inout  wire           scl,
    inout  wire           sda,
    i2c_target_if.slave   bus
);

    localparam int              HOLD_W    = $clog2(SDA_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SDA_HOLD);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl_filter (
        .clk_in (clk_in), .rst_n (rst_n), .line_in (scl),
        .level  (scl_lvl), .rise (scl_rise), .fall (scl_fall)
    );

    i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda_filter (
        .clk_in (clk_in), .rst_n (rst_n), .line_in (sda),
        .level  (sda_lvl), .rise (sda_rise), .fall (sda_fall)
    );

    i2c_state_e        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              sda_oe_q, sda_oe_d;
    logic              scl_oe_q, scl_oe_d;
    logic              nack_q, nack_d;
    logic              tx_loaded_q, tx_loaded_d;
    logic              addressed_q, addressed_d;
    logic              read_mode_q, read_mode_d;
    logic              tx_request_q, tx_request_d;
    logic              rx_valid_q, rx_valid_d;
    logic              start_seen_q, start_seen_d;
    logic              stop_seen_q, stop_seen_d;
    logic              master_nack_q, master_nack_d;
    logic              tx_underrun_q, tx_underrun_d;

    logic              start_det, stop_det, accept, hold_strobe, drive_low;
    logic [7:0]        byte_in;

    assign start_det   = sda_fall & scl_lvl;
    assign stop_det    = sda_rise & scl_lvl;
    assign accept      = tx_request_q & bus.tx_valid;
    assign hold_strobe = (hold_cnt_q == HOLD_W'(1));
    assign byte_in     = {shift_q[6:0], sda_lvl};

    // State register and all protocol flops.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            tx_shift_q    <= '0;
            rx_data_q     <= '0;
            hold_cnt_q    <= '0;
            sda_oe_q      <= 1'b0;
            scl_oe_q      <= 1'b0;
            nack_q        <= 1'b0;
            tx_loaded_q   <= 1'b0;
            addressed_q   <= 1'b0;
            read_mode_q   <= 1'b0;
            tx_request_q  <= 1'b0;
            rx_valid_q    <= 1'b0;
            start_seen_q  <= 1'b0;
            stop_seen_q   <= 1'b0;
            master_nack_q <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            tx_shift_q    <= tx_shift_d;
            rx_data_q     <= rx_data_d;
            hold_cnt_q    <= hold_cnt_d;
            sda_oe_q      <= sda_oe_d;
            scl_oe_q      <= scl_oe_d;
            nack_q        <= nack_d;
            tx_loaded_q   <= tx_loaded_d;
            addressed_q   <= addressed_d;
            read_mode_q   <= read_mode_d;
            tx_request_q  <= tx_request_d;
            rx_valid_q    <= rx_valid_d;
            start_seen_q  <= start_seen_d;
            stop_seen_q   <= stop_seen_d;
            master_nack_q <= master_nack_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    // Level SDA should take in the current state once the hold time expires.
    always_comb begin
        drive_low = 1'b0;
        case (state_q)
            ST_ADDR_ACK:  drive_low = 1'b1;
            ST_WRITE_ACK: drive_low = (nack_q != I2C_NACK);
            ST_READ_BYTE: drive_low = ~tx_shift_q[7];
            default:      drive_low = 1'b0;
        endcase
    end

    // Next-state, datapath and output pulses.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        tx_shift_d    = tx_shift_q;
        rx_data_d     = rx_data_q;
        hold_cnt_d    = hold_cnt_q;
        sda_oe_d      = sda_oe_q;
        scl_oe_d      = scl_oe_q;
        nack_d        = nack_q;
        tx_loaded_d   = tx_loaded_q;
        addressed_d   = addressed_q;
        read_mode_d   = read_mode_q;
        tx_request_d  = tx_request_q;
        rx_valid_d    = 1'b0;
        start_seen_d  = 1'b0;
        stop_seen_d   = 1'b0;
        master_nack_d = 1'b0;
        tx_underrun_d = 1'b0;

        // SDA only moves a fixed delay after SCL falls, so a bit driven in
        // the low phase is held through the following high phase.
        if (scl_fall) begin
            hold_cnt_d = HOLD_LOAD;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
        if (hold_strobe) begin
            sda_oe_d = drive_low;
        end

        if (accept) begin
            tx_shift_d   = bus.tx_data;
            tx_loaded_d  = 1'b1;
            tx_request_d = 1'b0;
            // While stretching, present the first bit now; SCL is let go one
            // cycle later so the pair can never look like a START/STOP.
            if (scl_oe_q) begin
                state_d     = ST_READ_BYTE;
                bit_cnt_d   = '0;
                tx_loaded_d = 1'b0;
                sda_oe_d    = ~bus.tx_data[7];
            end
        end

        case (state_q)
            ST_ADDR: begin
                if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        if (byte_in[7:1] == ADDRESS) begin
                            state_d      = ST_ADDR_ACK;
                            addressed_d  = 1'b1;
                            read_mode_d  = byte_in[0];
                            tx_request_d = byte_in[0];
                            tx_loaded_d  = 1'b0;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
            end
            ST_ADDR_ACK: begin
                if (scl_rise) begin
                    state_d   = read_mode_q ? ST_READ_LOAD : ST_WRITE_BYTE;
                    bit_cnt_d = '0;
                end
            end
            ST_WRITE_BYTE: begin
                if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = byte_in;
                        rx_valid_d = 1'b1;
                        state_d    = ST_WRITE_ACK;
                    end
                end
            end
            ST_WRITE_ACK: begin
                if (scl_fall) begin
                    nack_d = bus.rx_nack;
                end
                if (scl_rise) begin
                    state_d   = ST_WRITE_BYTE;
                    bit_cnt_d = '0;
                end
            end
            ST_READ_LOAD: begin
                // The falling edge closing the ACK slot decides: send, stretch
                // or substitute 0xFF.
                if (scl_fall && !scl_oe_q) begin
                    if (tx_loaded_q || accept) begin
                        state_d     = ST_READ_BYTE;
                        bit_cnt_d   = '0;
                        tx_loaded_d = 1'b0;
                    end else if (CLOCK_STRETCHING) begin
                        scl_oe_d = 1'b1;
                    end else begin
                        tx_shift_d    = 8'hFF;
                        tx_underrun_d = 1'b1;
                        tx_request_d  = 1'b0;
                        state_d       = ST_READ_BYTE;
                        bit_cnt_d     = '0;
                    end
                end
            end
            ST_READ_BYTE: begin
                if (scl_oe_q) begin
                    scl_oe_d = 1'b0;
                end
                if (scl_rise) begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b1};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = ST_READ_ACK;
                    end
                end
            end
            ST_READ_ACK: begin
                if (scl_rise) begin
                    if (sda_lvl == I2C_ACK) begin
                        state_d      = ST_READ_LOAD;
                        tx_request_d = 1'b1;
                        tx_loaded_d  = 1'b0;
                    end else begin
                        master_nack_d = 1'b1;
                        state_d       = ST_IGNORE;
                    end
                end
            end
            default: begin
            end
        endcase

        // START/STOP override everything, including pending read data.
        if (start_det || stop_det) begin
            state_d      = start_det ? ST_ADDR : ST_IDLE;
            start_seen_d = start_det;
            stop_seen_d  = stop_det;
            bit_cnt_d    = '0;
            hold_cnt_d   = '0;
            addressed_d  = 1'b0;
            sda_oe_d     = 1'b0;
            scl_oe_d     = 1'b0;
            tx_request_d = 1'b0;
            tx_loaded_d  = 1'b0;
        end
    end

    // Open-drain outputs; reset releases the lines in the same cycle.
    assign sda = (sda_oe_q && rst_n) ? 1'b0 : 1'bz;
    assign scl = (scl_oe_q && rst_n && CLOCK_STRETCHING) ? 1'b0 : 1'bz;

    assign bus.start_seen  = start_seen_q;
    assign bus.stop_seen   = stop_seen_q;
    assign bus.addressed   = addressed_q;
    assign bus.read_mode   = read_mode_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_request  = tx_request_q;
    assign bus.master_nack = master_nack_q;
    assign bus.tx_underrun = tx_underrun_q;

endmodule : i2c_target
`default_nettype wire
